cic_interp_filter: RTL and testbench
====================================

Name: cic_interp_filter

Overview:
Single-clock, parametrised CIC interpolation filter. It replaces the fixed dual-clock interpolator in the CIC/Interpolation tree. The stage count, data width and maximum rate are set at elaboration. The interpolation factor R = 2^rate is run-time selectable. The input side uses a valid/ready handshake at the low rate. The output produces one sample per clock, scaled to unity DC gain, with saturation and an underrun flag.

Parameters:
IN_W, 8, input/output sample width (two's complement)
N, 3, number of comb and integrator stages (1..6)
R_MAX_LOG2, 4, maximum log2 of interpolation factor
RATE_DEF, 2, log2 of the rate loaded at reset
ACC_W, IN_W+N*R_MAX_LOG2, internal width of comb/integrator registers (derived, not overridden)
RL_W, $clog2(R_MAX_LOG2+1), width of rate port (derived)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  asynchronous, active-low reset
en_i  in  1  run enable; 0 = flush and idle
rate_log2_i  in  RL_W  log2(R); sampled only while en_i=0
in_data_i  in  IN_W  input sample, signed
in_valid_i  in  1  input sample valid
in_ready_o  out  1  block accepts a sample this cycle
out_data_o  out  IN_W  output sample, signed
out_valid_o  out  1  out_data_o valid this cycle
underrun_o  out  1  sticky: input slot missed since last enable

Behaviour:
- Reset (rst_n_i=0, async): all comb delays, integrators, zero-stuff register, phase counter, out_data_o, out_valid_o and underrun_o go to 0. The rate register goes to RATE_DEF.
- en_i=0 (synchronous): same clear as reset, except the rate register loads min(rate_log2_i, R_MAX_LOG2) every cycle. in_ready_o=0. rate_log2_i is ignored while en_i=1.
- out_valid_o is a registered copy of en_i. It is 1 on every cycle after an edge that sampled en_i=1. Data is zero until the pipeline fills.
- Phase counter p: runs 0..R-1 and wraps while en_i=1. It is held at 0 while en_i=0.
- in_ready_o = en_i & (p==0). This is combinational from en_i and the p register.
- Accept = in_valid_i & in_ready_o.
- Input slot (p==0):
  - On accept, in_data_i, sign-extended to ACC_W, passes through the N combs: y_k = x_k - d_k, with d_k <= x_k. The chain is combinational; all comb delays update on that edge. The zero-stuff register u loads y_N.
  - If p==0 and in_valid_i=0, a zero sample goes through the combs, u loads the comb output, and underrun_o sets. underrun_o clears only on en_i=0 or reset.
- Non-input cycles (p!=0): u <= 0 and comb delays hold.
- Integrators are pipelined and update every enabled cycle: I_1 <= I_1 + u, then I_k <= I_k + I_(k-1) for k = 2..N.
- All comb/integrator arithmetic wraps modulo 2^ACC_W. No saturation is applied internally.
- Output: out_data_o <= sat_IN_W(I_N >>> ((N-1)*rate)), using arithmetic shift (floor) and saturation to [-2^(IN_W-1), 2^(IN_W-1)-1]. DC gain is exactly 1.
- Latency: the first output contribution of a sample accepted at edge k appears on out_data_o after edge k+N+1.
- Rate = 0 (R=1): every cycle is an input slot. The response is a delayed pass-through.
- Simultaneous en_i falling with an accept: the flush wins and the sample is discarded.
- Reset mid-stream: outputs return to 0 immediately. Operation restarts cleanly at phase 0 on the next enable.
- Impulse response: 1..N-fold convolution of length-R boxcars at output rate, of length N(R-1)+1, scaled by 2^-((N-1)*rate).

Test Plan:
- Defaults (N=3, rate=2), single accepted 127 then zeros -> ten outputs starting N+1 edges after the accept: 7,23,47,79,95,95,79,47,23,7; then 0. underrun_o=0.
- Constant input 100 every slot, rate=2 -> after transient, out_data_o=100 every cycle. in_ready_o is high 1 cycle in 4.
- Constant -128 at rate=4 (R=16) -> steady -128, no wrap artefacts. Constant 127 -> steady 127.
- Withhold in_valid_i at one input slot with DC 100 applied -> underrun_o rises the edge after that slot and stays 1. Output dips, then recovers to 100. en_i low for 1 cycle -> underrun_o=0 and out_data_o=0.
- While en_i=1, drive rate_log2_i=3 -> no effect. Drop en_i, set rate 3, re-enable -> in_ready_o period 8. rate_log2_i=7 while idle -> clamped to 4 (period 16).
- Assert rst_n_i mid-stream, asynchronously between edges -> out_data_o, out_valid_o, in_ready_o drop to 0 immediately. After release with en_i=1, the impulse test reproduces exact values.

Source files
------------

// File: rtl/cic_interp_filter.sv
// rtl/cic_interp_filter.sv - single-clock CIC interpolator with run-time rate, DC-unity scaling and saturation
//
// Purpose: N-stage CIC interpolation by R = 2^rate. Samples enter at the low
// rate through a valid/ready handshake. They pass through the combs and are
// zero-stuffed. The N integrators run every enabled cycle, so the output rate
// is one sample per clock. The output is scaled by 2^-((N-1)*rate) so that the
// DC gain is exactly 1, then saturated to IN_W bits.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   en_i         run enable; low flushes all state and loads the rate
//   rate_log2_i  log2(R), sampled only while en_i is low (clamped to R_MAX_LOG2)
//   in_data_i    signed input sample
//   in_valid_i   input sample valid
//   in_ready_o   high on input-slot cycles (phase 0) while enabled
//   out_data_o   signed, scaled, saturated output sample
//   out_valid_o  registered copy of en_i
//   underrun_o   sticky: an input slot passed without a valid sample
module cic_interp_filter #(
  parameter  int IN_W       = 8,
  parameter  int N          = 3,
  parameter  int R_MAX_LOG2 = 4,
  parameter  int RATE_DEF   = 2,
  localparam int ACC_W      = IN_W + N * R_MAX_LOG2,
  localparam int RL_W       = $clog2(R_MAX_LOG2 + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [RL_W-1:0]        rate_log2_i,
  input  logic signed [IN_W-1:0] in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic signed [IN_W-1:0] out_data_o,
  output logic                   out_valid_o,
  output logic                   underrun_o
);

  // (N-1) <= 5 < 8, so three extra bits hold the largest shift amount.
  localparam int SH_W = RL_W + 3;

  logic [RL_W-1:0]         rate_q;
  logic [R_MAX_LOG2-1:0]   phase_q;
  logic [R_MAX_LOG2:0]     r_val;
  logic [R_MAX_LOG2-1:0]   phase_last;
  logic [RL_W-1:0]         rate_clamped;
  logic                    slot;

  logic signed [ACC_W-1:0] comb_x [N+1];
  logic signed [ACC_W-1:0] comb_d [N];
  logic signed [ACC_W-1:0] integ  [N];
  logic signed [ACC_W-1:0] u_q;

  logic [SH_W-1:0]         shamt;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-IN_W:0]     sat_hi;
  logic [IN_W-1:0]         sat_val;

  // R is one wider than the phase counter so that R_MAX itself is representable.
  assign r_val        = (R_MAX_LOG2 + 1)'(1) << rate_q;
  assign phase_last   = R_MAX_LOG2'(r_val - (R_MAX_LOG2 + 1)'(1));
  assign rate_clamped = (rate_log2_i > RL_W'(R_MAX_LOG2)) ? RL_W'(R_MAX_LOG2) : rate_log2_i;

  assign slot = en_i & (phase_q == '0);
  // Gated by reset so a held-off block never advertises readiness.
  assign in_ready_o = slot & rst_n_i;

  // Comb chain: a missing sample at an input slot is treated as zero.
  always_comb begin
    comb_x[0] = in_valid_i ? {{(ACC_W - IN_W){in_data_i[IN_W-1]}}, in_data_i} : '0;
    for (int k = 0; k < N; k++) begin
      comb_x[k+1] = comb_x[k] - comb_d[k];
    end
  end

  // Unity-DC scaling: the interpolator gain is R^(N-1).
  assign shamt   = SH_W'(rate_q) * SH_W'(N - 1);
  assign shifted = integ[N-1] >>> shamt;
  assign sat_hi  = shifted[ACC_W-1:IN_W-1];

  always_comb begin
    sat_val = shifted[IN_W-1:0];
    if (!((&sat_hi) || ~(|sat_hi))) begin
      sat_val = shifted[ACC_W-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rate_q      <= RL_W'(RATE_DEF);
      phase_q     <= '0;
      u_q         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      underrun_o  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        comb_d[k] <= '0;
        integ[k]  <= '0;
      end
    end else if (!en_i) begin
      rate_q      <= rate_clamped;
      phase_q     <= '0;
      u_q         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      underrun_o  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        comb_d[k] <= '0;
        integ[k]  <= '0;
      end
    end else begin
      out_valid_o <= 1'b1;
      phase_q     <= (phase_q == phase_last) ? '0 : phase_q + 1'b1;
      if (slot) begin
        for (int k = 0; k < N; k++) begin
          comb_d[k] <= comb_x[k];
        end
        u_q <= comb_x[N];
        if (!in_valid_i) begin
          underrun_o <= 1'b1;
        end
      end else begin
        u_q <= '0;
      end
      // Pipelined integrators: each stage consumes the previous stage's old value.
      integ[0] <= integ[0] + u_q;
      for (int k = 1; k < N; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      out_data_o <= sat_val;
    end
  end

endmodule

// File: tb/tb_cic_interp_filter.sv
// tb/tb_cic_interp_filter.sv - self-checking bench for cic_interp_filter
module tb_cic_interp_filter;

  localparam int IN_W       = 8;
  localparam int N          = 3;
  localparam int R_MAX_LOG2 = 4;
  localparam int RATE_DEF   = 2;
  localparam int RL_W       = 3;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic                   en_i;
  logic [RL_W-1:0]        rate_log2_i;
  logic signed [IN_W-1:0] in_data_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic signed [IN_W-1:0] out_data_o;
  logic                   out_valid_o;
  logic                   underrun_o;

  always #5 clk_i = ~clk_i;

  cic_interp_filter #(
    .IN_W(IN_W), .N(N), .R_MAX_LOG2(R_MAX_LOG2), .RATE_DEF(RATE_DEF)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .rate_log2_i(rate_log2_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .underrun_o(underrun_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: zero-stuffed input stream convolved with the N-fold boxcar.
  int     mrate;
  int     ph;
  bit     mund;
  int     v[$];
  longint h[$];

  typedef struct {
    int rate_idle;
    int rate_run;
    int dc;
    int exp_out;
    int exp_ready64;
  } vec_t;

  vec_t vecs[6];
  int   imp_exp[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_h(input int rate);
    longint tmp[$];
    int r;
    r = 1 << rate;
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      tmp.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        longint acc;
        acc = 0;
        for (int j = 0; j < r; j++) begin
          if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
        end
        tmp.push_back(acc);
      end
      h = tmp;
    end
  endfunction

  function automatic int model_out(input int t);
    longint s;
    s = 0;
    for (int j = 0; j < h.size(); j++) begin
      int idx;
      idx = t - (N + 1) - j;
      if (idx >= 0 && idx < v.size()) s += h[j] * longint'(v[idx]);
    end
    s = s >>> ((N - 1) * mrate);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  task automatic model_clear();
    v.delete();
    ph   = 0;
    mund = 1'b0;
  endtask

  // One clock: drive inputs, check ready, clock, update model, check outputs.
  task automatic cycle(input bit en, input bit valid, input int data, input int rate_in);
    int  exp_o;
    bit  exp_v;
    bit  slot;
    en_i        = en;
    in_valid_i  = valid;
    in_data_i   = IN_W'(data);
    rate_log2_i = RL_W'(rate_in);
    #1;
    check("in_ready", int'(in_ready_o), int'(en && (ph % (1 << mrate) == 0)));
    @(posedge clk_i);
    if (!en) begin
      model_clear();
      mrate = (rate_in > R_MAX_LOG2) ? R_MAX_LOG2 : rate_in;
      build_h(mrate);
      exp_o = 0;
      exp_v = 1'b0;
    end else begin
      slot = (ph % (1 << mrate) == 0);
      v.push_back((slot && valid) ? data : 0);
      if (slot && !valid) mund = 1'b1;
      exp_o = model_out(ph);
      ph++;
      exp_v = 1'b1;
    end
    #1;
    check("out_data", int'(out_data_o), exp_o);
    check("out_valid", int'(out_valid_o), int'(exp_v));
    check("underrun", int'(underrun_o), int'(mund));
  endtask

  // Expects phase 0 and rate 2 on entry.
  task automatic run_impulse(input string tag);
    int got[15];
    cycle(1'b1, 1'b1, 127, 0);
    got[0] = int'(out_data_o);
    for (int i = 1; i < 15; i++) begin
      cycle(1'b1, 1'b1, 0, 0);
      got[i] = int'(out_data_o);
    end
    for (int i = 1; i < 4; i++) check({tag, "_pre"}, got[i], 0);
    for (int i = 0; i < 11; i++) check({tag, "_tap"}, got[i+4], imp_exp[i]);
    check({tag, "_underrun"}, int'(underrun_o), 0);
  endtask

  initial begin
    int cnt;
    imp_exp = '{7, 23, 47, 79, 95, 95, 79, 47, 23, 7, 0};
    vecs[0] = '{2, 3, 100, 100, 16};
    vecs[1] = '{4, 0, -128, -128, 4};
    vecs[2] = '{4, 0, 127, 127, 4};
    vecs[3] = '{3, 0, 100, 100, 8};
    vecs[4] = '{7, 1, 50, 50, 4};
    vecs[5] = '{0, 0, -77, -77, 64};

    rst_n_i = 1'b0; en_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; rate_log2_i = '0;
    mrate = RATE_DEF;
    build_h(mrate);
    model_clear();
    #12;
    check("rst_out_data", int'(out_data_o), 0);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_underrun", int'(underrun_o), 0);
    check("rst_in_ready", int'(in_ready_o), 0);
    rst_n_i = 1'b1;

    // Impulse straight out of reset uses the default rate.
    run_impulse("impulse");

    // DC table: rate, clamping, rate ignored while running, ready period.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 0, vecs[i].rate_idle);
      repeat (150) cycle(1'b1, 1'b1, vecs[i].dc, vecs[i].rate_run);
      cnt = 0;
      repeat (64) begin
        cycle(1'b1, 1'b1, vecs[i].dc, vecs[i].rate_run);
        if (in_ready_o) cnt++;
      end
      check("dc_out", int'(out_data_o), vecs[i].exp_out);
      check("dc_ready_count", cnt, vecs[i].exp_ready64);
    end

    // Underrun: skip one input slot under DC 100.
    cycle(1'b0, 1'b0, 0, 2);
    repeat (40) cycle(1'b1, 1'b1, 100, 0);
    while (ph % 4 != 0) cycle(1'b1, 1'b1, 100, 0);
    cycle(1'b1, 1'b0, 0, 0);
    check("underrun_set", int'(underrun_o), 1);
    repeat (40) cycle(1'b1, 1'b1, 100, 0);
    check("underrun_recover", int'(out_data_o), 100);
    check("underrun_sticky", int'(underrun_o), 1);
    cycle(1'b0, 1'b0, 0, 2);
    check("flush_underrun", int'(underrun_o), 0);
    check("flush_out", int'(out_data_o), 0);

    // Randomised streams with random rate, gaps and enable drops.
    for (int r = 0; r < 6; r++) begin
      cycle(1'b0, 1'b0, 0, int'($urandom_range(0, 7)));
      repeat (150) begin
        cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 7)));
      end
    end

    // Asynchronous reset between edges, mid-stream.
    cycle(1'b0, 1'b0, 0, 2);
    repeat (40) cycle(1'b1, 1'b1, 100, 0);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("arst_out_data", int'(out_data_o), 0);
    check("arst_out_valid", int'(out_valid_o), 0);
    check("arst_in_ready", int'(in_ready_o), 0);
    model_clear();
    mrate = RATE_DEF;
    build_h(mrate);
    @(posedge clk_i);
    #1;
    check("arst_hold", int'(out_data_o), 0);
    rst_n_i = 1'b1;
    run_impulse("impulse_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
